// File: rtl/fm_synth_pkg.sv
// fm_synth_pkg: shared widths and FSM state encoding for the FM operator sequencer
package fm_synth_pkg;

    localparam int DEF_WI_OUT   = 2;
    localparam int DEF_WF_OUT   = 16;
    localparam int SAMPLE_W     = DEF_WI_OUT + DEF_WF_OUT;
    localparam int MOD_SCALAR_W = 8;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE    = 2'd0;
    localparam state_t S_ISSUE   = 2'd1;
    localparam state_t S_WAIT    = 2'd2;
    localparam state_t S_CAPTURE = 2'd3;

endpackage

// File: rtl/phase_acc_bank.sv
// phase_acc_bank: one phase accumulator per (channel, operator); returns the phase before update
module phase_acc_bank #(
    parameter int DEPTH = 32,
    parameter int W     = 32,
    parameter int IW    = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] idx_i,
    input  logic          add_en_i,
    input  logic          clr_i,
    input  logic [W-1:0]  inc_i,
    output logic [W-1:0]  phase_o
);

    logic [W-1:0] mem_q [DEPTH];

    assign phase_o = mem_q[idx_i];

    // accumulate with natural wrap, or hold the selected phase at zero when cleared
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (add_en_i) begin
            mem_q[idx_i] <= clr_i ? '0 : mem_q[idx_i] + inc_i;
        end
    end

endmodule

// File: rtl/fm_op_sequencer.sv
// fm_op_sequencer: serial N-operator FM chain over all voices through one shared LUT; FM_OP_FEEDBACK_EN adds op0 self-feedback
module fm_op_sequencer
    import fm_synth_pkg::*;
#(
    parameter int NUM_CHANNELS  = 16,
    parameter int NUM_OPS       = 2,
    parameter int NUM_BITS      = 32,
    parameter int WI_OUT        = DEF_WI_OUT,
    parameter int WF_OUT        = DEF_WF_OUT,
    parameter int LUT_ADDR_BITS = 15,
    parameter int LATENCY       = 3,
    parameter int MOD_SHIFT     = 6
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     frame_start,
    input  logic [NUM_CHANNELS-1:0]                  note_on,
    input  logic [NUM_CHANNELS*NUM_OPS*NUM_BITS-1:0] tuning_in,
    input  logic [NUM_OPS*MOD_SCALAR_W-1:0]          mod_scalar,
    output logic [LUT_ADDR_BITS-1:0]                 lut_addr,
    input  logic [WI_OUT+WF_OUT-1:0]                 lut_data,
    output logic [WI_OUT+WF_OUT-1:0]                 sample_out,
    output logic [$clog2(NUM_CHANNELS)-1:0]          sample_chan,
    output logic                                     sample_valid,
    output logic                                     busy,
    output logic                                     frame_overrun
);

    localparam int SW = WI_OUT + WF_OUT;
    localparam int CW = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1;
    localparam int OW = NUM_OPS > 1 ? $clog2(NUM_OPS) : 1;
    localparam int NV = NUM_CHANNELS * NUM_OPS;
    localparam int IW = NV > 1 ? $clog2(NV) : 1;
    localparam int WW = LATENCY > 1 ? $clog2(LATENCY) : 1;

    state_t                   state_q, state_d;
    logic [CW-1:0]            chan_q, chan_d;
    logic [OW-1:0]            op_q, op_d;
    logic [WW-1:0]            wcnt_q, wcnt_d;
    logic [SW-1:0]            prev_q, prev_d;
    logic [LUT_ADDR_BITS-1:0] addr_q, addr_d;
    logic [SW-1:0]            sout_q, sout_d;
    logic [CW-1:0]            schan_q, schan_d;
    logic                     svld_q, svld_d;
    logic                     ovr_q, ovr_d;

    logic                     issue, cap, last_op, last_chan, gate;
    logic [IW-1:0]            idx;
    logic [NUM_BITS-1:0]      phase, tuning, src_ext, ms_ext, offset, sum;
    logic [SW-1:0]            src;
    logic [MOD_SCALAR_W-1:0]  ms;

    assign issue     = state_q == S_ISSUE;
    assign cap       = state_q == S_CAPTURE;
    assign last_op   = op_q == OW'(NUM_OPS - 1);
    assign last_chan = chan_q == CW'(NUM_CHANNELS - 1);
    assign gate      = note_on[chan_q];
    assign idx       = IW'(chan_q) * IW'(NUM_OPS) + IW'(op_q);
    assign tuning    = tuning_in[idx*NUM_BITS +: NUM_BITS];
    assign ms        = mod_scalar[op_q*MOD_SCALAR_W +: MOD_SCALAR_W];

`ifdef FM_OP_FEEDBACK_EN
    logic [SW-1:0] fb_q [NUM_CHANNELS];
    logic [SW-1:0] fb_d [NUM_CHANNELS];

    assign src = (op_q == '0) ? fb_q[chan_q] : prev_q;

    // op0 output is remembered per voice; a silent voice keeps no feedback history
    always_comb begin
        for (int c = 0; c < NUM_CHANNELS; c++)
            fb_d[c] = !note_on[c] ? '0 : (cap && op_q == '0 && chan_q == CW'(c)) ? lut_data : fb_q[c];
    end

    // feedback storage
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CHANNELS; c++) fb_q[c] <= rst ? '0 : fb_d[c];
    end
`else
    assign src = (op_q == '0) ? '0 : prev_q;
`endif

    // previous operator output, sign-extended, scaled by depth and aligned to phase
    assign src_ext = {{(NUM_BITS-SW){src[SW-1]}}, src};
    assign ms_ext  = {{(NUM_BITS-MOD_SCALAR_W){1'b0}}, ms};
    assign offset  = (src_ext * ms_ext) << MOD_SHIFT;
    assign sum     = phase + offset;

    assign addr_d  = issue ? sum[NUM_BITS-1 -: LUT_ADDR_BITS] : addr_q;
    assign prev_d  = (issue && op_q == '0) ? '0 : cap ? lut_data : prev_q;
    assign sout_d  = (cap && last_op) ? (gate ? lut_data : '0) : sout_q;
    assign schan_d = (cap && last_op) ? chan_q : schan_q;
    assign svld_d  = cap && last_op;
    assign ovr_d   = ovr_q | (frame_start && state_q != S_IDLE);

    phase_acc_bank #(
        .DEPTH (NV),
        .W     (NUM_BITS),
        .IW    (IW)
    ) u_bank (
        .clk      (clk),
        .rst      (rst),
        .idx_i    (idx),
        .add_en_i (issue),
        .clr_i    (!gate),
        .inc_i    (tuning),
        .phase_o  (phase)
    );

    // frame walker: op inner, channel outer, LATENCY+1 cycles per operator
    always_comb begin
        state_d = state_q;
        chan_d  = chan_q;
        op_d    = op_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            S_IDLE:  state_d = frame_start ? S_ISSUE : S_IDLE;
            S_ISSUE: begin
                state_d = (LATENCY > 1) ? S_WAIT : S_CAPTURE;
                wcnt_d  = '0;
            end
            S_WAIT: begin
                state_d = (wcnt_q == WW'(LATENCY - 2)) ? S_CAPTURE : S_WAIT;
                wcnt_d  = wcnt_q + WW'(1);
            end
            default: begin
                state_d = (last_op && last_chan) ? S_IDLE : S_ISSUE;
                op_d    = last_op ? '0 : op_q + OW'(1);
                chan_d  = last_op ? (last_chan ? '0 : chan_q + CW'(1)) : chan_q;
            end
        endcase
    end

    // sequencer and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            chan_q  <= '0;
            op_q    <= '0;
            wcnt_q  <= '0;
            prev_q  <= '0;
            addr_q  <= '0;
            sout_q  <= '0;
            schan_q <= '0;
            svld_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            op_q    <= op_d;
            wcnt_q  <= wcnt_d;
            prev_q  <= prev_d;
            addr_q  <= addr_d;
            sout_q  <= sout_d;
            schan_q <= schan_d;
            svld_q  <= svld_d;
            ovr_q   <= ovr_d;
        end
    end

    assign lut_addr      = addr_q;
    assign sample_out    = sout_q;
    assign sample_chan   = schan_q;
    assign sample_valid  = svld_q;
    assign busy          = state_q != S_IDLE;
    assign frame_overrun = ovr_q;

endmodule

// File: tb/tb_fm_op_sequencer.sv
// tb_fm_op_sequencer: randomized frames checked against a per-frame behavioural model of the FM chain
module tb_fm_op_sequencer;

    localparam int NC  = 2;
    localparam int NO  = 2;
    localparam int LAT = 3;
    localparam int NB  = 32;
    localparam int SW  = 18;
    localparam int AB  = 15;
    localparam int MS  = 6;
    localparam int NV  = NC * NO;
    localparam int FL  = NV * (LAT + 1);
    localparam int CB  = $clog2(NC);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             frame_start = 1'b0;
    logic [NC-1:0]    note_on = '0;
    logic [NV*NB-1:0] tuning_in = '0;
    logic [NO*8-1:0]  mod_scalar = '0;
    logic [AB-1:0]    lut_addr;
    logic [SW-1:0]    lut_data = '0;
    logic [SW-1:0]    lut_d1 = '0;
    logic [SW-1:0]    sample_out;
    logic [CB-1:0]    sample_chan;
    logic             sample_valid, busy, frame_overrun;

    int               checks = 0;
    int               errors = 0;
    logic             lut_const = 1'b0;
    logic [SW-1:0]    lut_key = '0;
    logic             exp_ovr = 1'b0;
    logic [NB-1:0]    ph [NV];
    logic [SW-1:0]    fb [NC];
    logic [AB-1:0]    exp_addr [NV];
    logic [SW-1:0]    exp_s [NC];

    always #5 clk = ~clk;

    fm_op_sequencer #(
        .NUM_CHANNELS  (NC),
        .NUM_OPS       (NO),
        .NUM_BITS      (NB),
        .WI_OUT        (2),
        .WF_OUT        (16),
        .LUT_ADDR_BITS (AB),
        .LATENCY       (LAT),
        .MOD_SHIFT     (MS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .frame_start   (frame_start),
        .note_on       (note_on),
        .tuning_in     (tuning_in),
        .mod_scalar    (mod_scalar),
        .lut_addr      (lut_addr),
        .lut_data      (lut_data),
        .sample_out    (sample_out),
        .sample_chan   (sample_chan),
        .sample_valid  (sample_valid),
        .busy          (busy),
        .frame_overrun (frame_overrun)
    );

    function automatic logic [SW-1:0] lut_f(input logic [AB-1:0] a);
        return lut_const ? 18'h04000 : ({a[2:0], a} ^ lut_key);
    endfunction

    always @(posedge clk) begin
        lut_d1   <= lut_f(lut_addr);
        lut_data <= lut_d1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NV; k++) ph[k] = '0;
        for (int c = 0; c < NC; c++) fb[c] = '0;
    endtask

    task automatic model_frame();
        logic [SW-1:0] prev, d;
        logic [NB-1:0] src, off, sum;
        int k;
        for (int c = 0; c < NC; c++) begin
            prev = '0;
            if (!note_on[c]) fb[c] = '0;
            for (int o = 0; o < NO; o++) begin
                k = c * NO + o;
`ifdef FM_OP_FEEDBACK_EN
                src = NB'($signed(o == 0 ? fb[c] : prev));
`else
                src = (o == 0) ? '0 : NB'($signed(prev));
`endif
                off = (src * NB'(mod_scalar[o*8 +: 8])) << MS;
                sum = ph[k] + off;
                exp_addr[k] = sum[NB-1 -: AB];
                ph[k] = note_on[c] ? ph[k] + tuning_in[k*NB +: NB] : '0;
                d = lut_f(exp_addr[k]);
                prev = d;
                if (o == 0) fb[c] = note_on[c] ? d : '0;
                if (o == NO - 1) exp_s[c] = note_on[c] ? d : '0;
            end
        end
    endtask

    task automatic run_frame(input int ovr_at);
        int busy_n, pulses, k;
        model_frame();
        busy_n = 0;
        pulses = 0;
        @(negedge clk);
        frame_start = 1'b1;
        for (int i = 1; i <= FL + 3; i++) begin
            @(negedge clk);
            frame_start = (i == ovr_at);
            if (busy) busy_n++;
            if (i >= 2 && (i - 2) % (LAT + 1) == 0 && (i - 2) / (LAT + 1) < NV) begin
                k = (i - 2) / (LAT + 1);
                if (note_on[k/NO]) check($sformatf("addr%0d", k), 32'(lut_addr), 32'(exp_addr[k]));
            end
            if (sample_valid) begin
                if (pulses < NC) begin
                    check("vcyc", i, (pulses + 1) * NO * (LAT + 1) + 1);
                    check("schan", 32'(sample_chan), pulses);
                    check("sout", 32'(sample_out), 32'(exp_s[pulses]));
                end
                pulses++;
            end
        end
        check("npulse", pulses, NC);
        check("busylen", busy_n, FL);
        check("ovr", 32'(frame_overrun), 32'(exp_ovr));
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_addr", 32'(lut_addr), 0);
        check("rst_sout", 32'(sample_out), 0);
        check("rst_schan", 32'(sample_chan), 0);
        check("rst_vld", 32'(sample_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ovr", 32'(frame_overrun), 0);
        rst = 1'b0;

        note_on = 2'b01;
        tuning_in[1*NB +: NB] = 32'h0100_0000;
        repeat (3) run_frame(0);

        tuning_in[0*NB +: NB] = 32'hFFFF_FF00;
        run_frame(0);
        tuning_in[0*NB +: NB] = 32'h0000_0200;
        repeat (2) run_frame(0);

        lut_const = 1'b1;
        note_on = 2'b11;
        tuning_in = '0;
        mod_scalar[1*8 +: 8] = 8'd4;
        repeat (2) run_frame(0);

        mod_scalar[0 +: 8] = 8'd1;
        repeat (2) run_frame(0);

        exp_ovr = 1'b1;
        run_frame(5);

        lut_const = 1'b0;
        for (int f = 0; f < 6; f++) begin
            for (int k = 0; k < NV; k++) tuning_in[k*NB +: NB] = $urandom;
            mod_scalar = NO*8'($urandom);
            note_on = NC'($urandom_range(0, (1 << NC) - 1));
            lut_key = SW'($urandom);
            run_frame(0);
        end

        note_on = 2'b11;
        @(negedge clk);
        frame_start = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            frame_start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_busy", 32'(busy), 0);
        check("mrst_vld", 32'(sample_valid), 0);
        check("mrst_addr", 32'(lut_addr), 0);
        check("mrst_ovr", 32'(frame_overrun), 0);
        exp_ovr = 1'b0;
        model_reset();
        repeat (2) run_frame(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
